// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu top level: arbiter FSM encoding, default
// bus widths and the index-width helper used by the arbiters.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    localparam int DEFAULT_ADDR_WIDTH = 32;
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int MAX_CORES          = 8;

    // Never returns 0, so a 1-core build still gets a 1-bit index.
    function automatic int index_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/dm_arbiter_picker.sv
// Combinational round-robin picker: searches the request vector starting
// just after the previous winner and returns a one-hot grant and its index.
module round_robin_picker
    import cpu_pkg::*;
#(
    parameter int cores     = 4,
    parameter int idx_width = index_width(cores)
) (
    input  logic [cores-1:0]     req,
    input  logic [idx_width-1:0] last,
    output logic [cores-1:0]     grant,
    output logic [idx_width-1:0] winner
);

    // Offsets 1..cores visit every core once, ending on 'last' itself, so a
    // lone requester that just won can still win again.
    always_comb begin
        int                   cand_int;
        logic [idx_width-1:0] cand;
        logic                 found;
        grant    = '0;
        winner   = '0;
        found    = 1'b0;
        cand_int = 0;
        cand     = '0;
        for (int k = 1; k <= cores; k++) begin
            cand_int = (int'(last) + k) % cores;
            cand     = idx_width'(cand_int);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                winner      = cand;
            end
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Shared data-memory arbiter: one transaction at a time, round-robin among
// the cores, fixed three-cycle request-to-ack latency.
module dm_arbiter
    import cpu_pkg::*;
#(
    parameter int cores      = 4,
    parameter int addr_width = DEFAULT_ADDR_WIDTH,
    parameter int data_width = DEFAULT_DATA_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [cores-1:0]            req,
    input  logic [cores-1:0]            we,
    input  logic [cores*addr_width-1:0] addr,
    input  logic [cores*data_width-1:0] wdata,
    output logic [cores-1:0]            ack,
    output logic [data_width-1:0]       rdata,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [addr_width-1:0]       mem_addr,
    output logic [data_width-1:0]       mem_wdata,
    input  logic [data_width-1:0]       mem_rdata
);

    localparam int idx_width = index_width(cores);
    localparam logic [idx_width-1:0] last_init = idx_width'(cores - 1);

    arb_state_t state;
    arb_state_t state_next;

    logic [idx_width-1:0]  last;
    logic [idx_width-1:0]  pick_idx;
    logic [cores-1:0]      pick_grant;
    logic                  req_any;

    logic [idx_width-1:0]  winner_hold;
    logic                  we_hold;
    logic [addr_width-1:0] addr_hold;
    logic [data_width-1:0] wdata_hold;

    logic                  we_sel;
    logic [addr_width-1:0] addr_sel;
    logic [data_width-1:0] wdata_sel;

    assign req_any = |req;

    round_robin_picker #(
        .cores     (cores),
        .idx_width (idx_width)
    ) u_picker (
        .req    (req),
        .last   (last),
        .grant  (pick_grant),
        .winner (pick_idx)
    );

    // The grant is one-hot, so an AND-OR mux selects the winner's fields.
    always_comb begin
        we_sel    = 1'b0;
        addr_sel  = '0;
        wdata_sel = '0;
        for (int i = 0; i < cores; i++) begin
            if (pick_grant[i]) begin
                we_sel    = we_sel | we[i];
                addr_sel  = addr_sel | addr[i*addr_width +: addr_width];
                wdata_sel = wdata_sel | wdata[i*data_width +: data_width];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last        <= last_init;
            winner_hold <= '0;
            we_hold     <= 1'b0;
            addr_hold   <= '0;
            wdata_hold  <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && req_any) begin
                winner_hold <= pick_idx;
                we_hold     <= we_sel;
                addr_hold   <= addr_sel;
                wdata_hold  <= wdata_sel;
            end
            if (state == ISSUE) begin
                last <= winner_hold;
            end
        end
    end

    // Strobes are also gated by reset so an aborted store never reaches memory.
    always_comb begin
        state_next = state;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        ack        = '0;
        rdata      = '0;
        case (state)
            IDLE: begin
                if (req_any) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                mem_en     = 1'b1;
                mem_we     = we_hold;
                state_next = RESP;
            end
            RESP: begin
                ack[winner_hold] = 1'b1;
                if (!we_hold) begin
                    rdata = mem_rdata;
                end
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (reset) begin
            state_next = IDLE;
            mem_en     = 1'b0;
            mem_we     = 1'b0;
            ack        = '0;
            rdata      = '0;
        end
    end

    assign mem_addr  = addr_hold;
    assign mem_wdata = wdata_hold;

    ack_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(ack));

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: a 4-core and a 1-core instance, each with a small
// registered-read memory, checked against a queue of expected completions.
module tb_dm_arbiter;

    typedef struct {
        int          core;
        logic [31:0] data;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    logic [3:0]   req4   = '0;
    logic [3:0]   we4    = '0;
    logic [127:0] addr4  = '0;
    logic [127:0] wdata4 = '0;
    logic [3:0]   ack4;
    logic [31:0]  rdata4;
    logic         mem_en4;
    logic         mem_we4;
    logic [31:0]  mem_addr4;
    logic [31:0]  mem_wdata4;
    logic [31:0]  mem_rdata4 = '0;

    logic [0:0]   req1   = '0;
    logic [0:0]   we1    = '0;
    logic [31:0]  addr1  = '0;
    logic [31:0]  wdata1 = '0;
    logic [0:0]   ack1;
    logic [31:0]  rdata1;
    logic         mem_en1;
    logic         mem_we1;
    logic [31:0]  mem_addr1;
    logic [31:0]  mem_wdata1;
    logic [31:0]  mem_rdata1 = '0;

    logic [31:0]  dm4 [16];
    logic [31:0]  dm1 [16];
    logic         pl_we4  = 1'b0;
    logic         pl_we1  = 1'b0;
    logic [3:0]   pl_addr = '0;
    logic [31:0]  pl_data = '0;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t exp1_q[$];

    dm_arbiter #(.cores(4), .addr_width(32), .data_width(32)) u_dut4 (
        .clk       (clk),
        .reset     (reset),
        .req       (req4),
        .we        (we4),
        .addr      (addr4),
        .wdata     (wdata4),
        .ack       (ack4),
        .rdata     (rdata4),
        .mem_en    (mem_en4),
        .mem_we    (mem_we4),
        .mem_addr  (mem_addr4),
        .mem_wdata (mem_wdata4),
        .mem_rdata (mem_rdata4)
    );

    dm_arbiter #(.cores(1), .addr_width(32), .data_width(32)) u_dut1 (
        .clk       (clk),
        .reset     (reset),
        .req       (req1),
        .we        (we1),
        .addr      (addr1),
        .wdata     (wdata1),
        .ack       (ack1),
        .rdata     (rdata1),
        .mem_en    (mem_en1),
        .mem_we    (mem_we1),
        .mem_addr  (mem_addr1),
        .mem_wdata (mem_wdata1),
        .mem_rdata (mem_rdata1)
    );

    // Behavioural data memories with a one-cycle registered read.
    always @(posedge clk) begin
        if (pl_we4) begin
            dm4[pl_addr] <= pl_data;
        end else if (mem_en4) begin
            if (mem_we4) dm4[mem_addr4[3:0]] <= mem_wdata4;
            else         mem_rdata4 <= dm4[mem_addr4[3:0]];
        end
        if (pl_we1) begin
            dm1[pl_addr] <= pl_data;
        end else if (mem_en1) begin
            if (mem_we1) dm1[mem_addr1[3:0]] <= mem_wdata1;
            else         mem_rdata1 <= dm1[mem_addr1[3:0]];
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got still running want finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic poke(input bit single, input int a, input logic [31:0] d);
        pl_addr = 4'(a);
        pl_data = d;
        if (single) pl_we1 = 1'b1;
        else        pl_we4 = 1'b1;
        @(negedge clk);
        pl_we4 = 1'b0;
        pl_we1 = 1'b0;
    endtask

    task automatic set_core(input int i, input bit r, input bit w, input logic [31:0] a,
                            input logic [31:0] d);
        req4[i]            = r;
        we4[i]             = w;
        addr4[i*32 +: 32]  = a;
        wdata4[i*32 +: 32] = d;
    endtask

    task automatic pulse_reset;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (ack4 !== 4'b0) begin
            errors++; $display("[TB] FAIL reset_ack4 got %b want %b", ack4, 4'b0);
        end
        checks++;
        if (mem_en4 !== 1'b0 || mem_we4 !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_strobes got en=%b we=%b want 0 0", mem_en4, mem_we4);
        end
        checks++;
        if (rdata4 !== 32'd0 || mem_addr4 !== 32'd0 || mem_wdata4 !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_data got rdata=%h addr=%h wdata=%h want 0", rdata4, mem_addr4, mem_wdata4);
        end
        checks++;
        if (ack1 !== 1'b0 || mem_en1 !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_single got ack=%b en=%b want 0 0", ack1, mem_en1);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_load;
        int   cyc;
        bit   seen;
        bit   stray;
        exp_t e;
        poke(1'b0, 5, 32'd6);
        set_core(2, 1'b1, 1'b0, 32'd5, 32'd0);
        exp_q.push_back('{core: 2, data: 32'd6});
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                checks++;
                if (mem_en4 !== 1'b1 || mem_we4 !== 1'b0 || mem_addr4 !== 32'd5) begin
                    errors++;
                    $display("[TB] FAIL load_issue got en=%b we=%b addr=%h want 1 0 5", mem_en4, mem_we4, mem_addr4);
                end
            end
            if (ack4 !== 4'b0) seen = 1'b1;
        end
        checks++;
        if (!seen || cyc != 2) begin
            errors++; $display("[TB] FAIL load_latency got %0d seen=%0b want 2", cyc, seen);
        end
        if (seen) begin
            e = exp_q.pop_front();
            checks++;
            if (ack4 !== 4'(1 << e.core) || rdata4 !== e.data) begin
                errors++;
                $display("[TB] FAIL load_result got ack=%b rdata=%h want ack=%b rdata=%h", ack4, rdata4, 4'(1 << e.core), e.data);
            end
        end
        req4[2] = 1'b0;
        stray = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (ack4 !== 4'b0) stray = 1'b1;
        end
        checks++;
        if (stray) begin
            errors++; $display("[TB] FAIL load_no_extra_ack got extra ack want none");
        end
    endtask

    task automatic test_store_load;
        int   cyc;
        int   we_cnt;
        bit   seen;
        exp_t e;
        for (int pass = 0; pass < 2; pass++) begin
            set_core(0, 1'b1, pass == 0, 32'd0, 32'd8);
            exp_q.push_back('{core: 0, data: (pass == 0) ? 32'd0 : 32'd8});
            cyc    = 0;
            we_cnt = 0;
            seen   = 1'b0;
            while (!seen && cyc < 10) begin
                @(negedge clk);
                cyc++;
                if (mem_we4 === 1'b1) we_cnt++;
                if (ack4 !== 4'b0) seen = 1'b1;
            end
            checks++;
            if (!seen || cyc != 2 || we_cnt != ((pass == 0) ? 1 : 0)) begin
                errors++;
                $display("[TB] FAIL store_load_we pass=%0d got cyc=%0d we_cycles=%0d want cyc=2 we_cycles=%0d", pass, cyc, we_cnt, (pass == 0) ? 1 : 0);
            end
            if (seen) begin
                e = exp_q.pop_front();
                checks++;
                if (ack4 !== 4'(1 << e.core) || rdata4 !== e.data) begin
                    errors++;
                    $display("[TB] FAIL store_load_result pass=%0d got ack=%b rdata=%h want ack=%b rdata=%h", pass, ack4, rdata4, 4'(1 << e.core), e.data);
                end
            end
            if (pass == 0) begin
                checks++;
                if (dm4[0] !== 32'd8) begin
                    errors++; $display("[TB] FAIL store_mem got %h want %h", dm4[0], 32'd8);
                end
            end
            req4[0] = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_simultaneous;
        int   want_t [2] = '{2, 5};
        int   t;
        int   got;
        exp_t e;
        poke(1'b0, 1, 32'd11);
        poke(1'b0, 3, 32'd33);
        pulse_reset();
        set_core(1, 1'b1, 1'b0, 32'd1, 32'd0);
        set_core(3, 1'b1, 1'b0, 32'd3, 32'd0);
        exp_q.push_back('{core: 1, data: 32'd11});
        exp_q.push_back('{core: 3, data: 32'd33});
        t   = 0;
        got = 0;
        while (got < 2 && t < 30) begin
            @(negedge clk);
            t++;
            if (ack4 !== 4'b0) begin
                e = exp_q.pop_front();
                checks++;
                if (ack4 !== 4'(1 << e.core) || rdata4 !== e.data || t != want_t[got]) begin
                    errors++;
                    $display("[TB] FAIL simul_ack%0d got ack=%b rdata=%h t=%0d want ack=%b rdata=%h t=%0d", got, ack4, rdata4, t, 4'(1 << e.core), e.data, want_t[got]);
                end
                req4[e.core] = 1'b0;
                got++;
            end
        end
        checks++;
        if (got != 2) begin
            errors++; $display("[TB] FAIL simul_count got %0d want 2", got);
        end
        @(negedge clk);
    endtask

    task automatic test_saturation;
        int   t;
        int   got;
        bit   stray;
        exp_t e;
        for (int i = 0; i < 4; i++) poke(1'b0, 10 + i, 32'd100 + 32'(i));
        pulse_reset();
        for (int i = 0; i < 4; i++) set_core(i, 1'b1, 1'b0, 32'd10 + 32'(i), 32'd0);
        for (int n = 0; n < 6; n++) exp_q.push_back('{core: n % 4, data: 32'd100 + 32'(n % 4)});
        t   = 0;
        got = 0;
        while (got < 6 && t < 60) begin
            @(negedge clk);
            t++;
            if (ack4 !== 4'b0) begin
                e = exp_q.pop_front();
                checks++;
                if (ack4 !== 4'(1 << e.core) || rdata4 !== e.data || t != 2 + 3 * got) begin
                    errors++;
                    $display("[TB] FAIL sat_ack%0d got ack=%b rdata=%h t=%0d want ack=%b rdata=%h t=%0d", got, ack4, rdata4, t, 4'(1 << e.core), e.data, 2 + 3 * got);
                end
                got++;
                if (got == 6) req4 = 4'b0;
            end
        end
        checks++;
        if (got != 6) begin
            errors++; $display("[TB] FAIL sat_count got %0d want 6", got);
        end
        req4  = 4'b0;
        stray = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (ack4 !== 4'b0) stray = 1'b1;
        end
        checks++;
        if (stray) begin
            errors++; $display("[TB] FAIL sat_drain got extra ack want none");
        end
    endtask

    task automatic test_reset_mid;
        int   cyc;
        bit   seen;
        exp_t e;
        poke(1'b0, 7, 32'h55);
        set_core(2, 1'b1, 1'b1, 32'd7, 32'h77);
        @(negedge clk);
        checks++;
        if (mem_en4 !== 1'b1 || mem_we4 !== 1'b1) begin
            errors++; $display("[TB] FAIL abort_issue got en=%b we=%b want 1 1", mem_en4, mem_we4);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (mem_we4 !== 1'b0 || mem_en4 !== 1'b0) begin
            errors++; $display("[TB] FAIL abort_we_drop got en=%b we=%b want 0 0", mem_en4, mem_we4);
        end
        @(negedge clk);
        checks++;
        if (ack4 !== 4'b0 || dm4[7] !== 32'h55) begin
            errors++; $display("[TB] FAIL abort_quiet got ack=%b mem=%h want ack=0000 mem=55", ack4, dm4[7]);
        end
        reset = 1'b0;
        exp_q.push_back('{core: 2, data: 32'd0});
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (ack4 !== 4'b0) seen = 1'b1;
        end
        checks++;
        if (!seen || cyc != 2) begin
            errors++; $display("[TB] FAIL abort_reserve got cyc=%0d seen=%0b want 2", cyc, seen);
        end
        if (seen) begin
            e = exp_q.pop_front();
            checks++;
            if (ack4 !== 4'(1 << e.core) || rdata4 !== e.data || dm4[7] !== 32'h77) begin
                errors++;
                $display("[TB] FAIL abort_result got ack=%b rdata=%h mem=%h want ack=%b rdata=%h mem=77", ack4, rdata4, dm4[7], 4'(1 << e.core), e.data);
            end
        end
        req4[2] = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_ack1(input int budget, output int cycles, output bit seen);
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (ack1 !== 1'b0) seen = 1'b1;
        end
    endtask

    task automatic test_single_core;
        logic [31:0] model [8];
        logic [31:0] a_val;
        logic [31:0] b_val;
        int          i;
        int          j;
        int          op;
        int          cyc;
        bit          seen;
        bit          w;
        int          ad;
        logic [31:0] d;
        exp_t        e;
        for (int k = 0; k < 8; k++) begin
            poke(1'b1, k, 32'(k + 1));
            model[k] = 32'(k + 1);
        end
        a_val = '0;
        b_val = '0;
        for (int k = 0; k < 16; k++) begin
            i  = k / 4;
            j  = 7 - i;
            op = k % 4;
            w  = (op >= 2);
            ad = (op == 0 || op == 2) ? i : j;
            d  = (op == 2) ? b_val : a_val;
            exp1_q.push_back('{core: 0, data: w ? 32'd0 : model[ad]});
            if (w) model[ad] = d;
            req1   = 1'b1;
            we1    = w;
            addr1  = 32'(ad);
            wdata1 = d;
            wait_ack1(10, cyc, seen);
            checks++;
            if (!seen || cyc != 2) begin
                errors++; $display("[TB] FAIL single_latency op=%0d got cyc=%0d seen=%0b want 2", k, cyc, seen);
            end
            if (seen) begin
                e = exp1_q.pop_front();
                checks++;
                if (rdata1 !== e.data) begin
                    errors++; $display("[TB] FAIL single_rdata op=%0d got %h want %h", k, rdata1, e.data);
                end
                if (op == 0) a_val = rdata1;
                if (op == 1) b_val = rdata1;
            end
            req1 = 1'b0;
            @(negedge clk);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (dm1[k] !== 32'(8 - k)) begin
                errors++; $display("[TB] FAIL reverse_mem%0d got %h want %h", k, dm1[k], 32'(8 - k));
            end
        end
    endtask

    initial begin
        $display("[TB] starting dm_arbiter bench");
        test_reset();
        test_single_load();
        test_store_load();
        test_simultaneous();
        test_saturation();
        test_reset_mid();
        test_single_core();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Shared data-memory arbiter for the multi-core `cpu` top level. It sits between the load/store ports of `cores` CPU cores and the single data memory `dm`. It accepts one request at a time under round-robin priority, issues it to memory, and returns the acknowledge and read data to the winning core. With `cores` = 1 it degenerates to a pass-through with fixed 3-cycle latency, so the 1-core and 4-core builds share one datapath.

## Interface
Parameters:
- `cores`, default 4: number of requesting cores, 1..8.
- `addr_width`, default 32: word address width.
- `data_width`, default 32: data word width.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset; one clock, synchronous reset, active-high.
- `req`  in  `cores`  per-core request; held high until the matching `ack`.
- `we`  in  `cores`  per-core write enable; 1 = store, 0 = load.
- `addr`  in  `cores*addr_width`  packed per-core word address; core i occupies bits [i*addr_width +: addr_width].
- `wdata`  in  `cores*data_width`  packed per-core store data.
- `ack`  out  `cores`  one-hot, one-cycle completion pulse.
- `rdata`  out  `data_width`  load data, valid only while `ack` is nonzero.
- `mem_en`  out  1  memory access strobe.
- `mem_we`  out  1  memory write strobe.
- `mem_addr`  out  `addr_width`  memory address.
- `mem_wdata`  out  `data_width`  memory write data.
- `mem_rdata`  in  `data_width`  memory read data, registered by memory one cycle after `mem_en`.

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If any `req` bit is high, pick a winner by round-robin, searching from `last+1` modulo `cores`.
  - Latch winner index, `we`, `addr` and `wdata` into holding registers, then go to ISSUE.
  - If no `req` bit is high, stay in IDLE.
- ISSUE:
  - Drive `mem_en`=1, `mem_we`=latched `we`, and `mem_addr`/`mem_wdata` from the holding registers.
  - Set `last` = winner. Go to RESP.
- RESP:
  - Pulse `ack[winner]`=1.
  - `rdata` = `mem_rdata` for a load, 0 for a store.
  - Go to IDLE unconditionally.
- Core contract: a core keeps `req`, `we`, `addr` and `wdata` stable from assertion until it sees `ack`.
- A core may present a new request on the cycle after its `ack`. It then competes normally in IDLE.
- Requests that arrive during ISSUE or RESP are not lost. They are sampled at the next IDLE.
- Fairness: a continuously requesting core is served within `cores` transactions.
- Outputs in IDLE: `mem_en`, `mem_we`, `ack` and `rdata` are all 0. `mem_addr` and `mem_wdata` hold their previous values (don't-care).

## Timing
- Request seen high in IDLE at cycle T: `mem_en` high at T+1, `ack` high at T+2. Round-trip latency is 3 cycles.
- Throughput is one transaction per 3 cycles, regardless of `cores`.
- A store becomes visible in `dm` at the end of cycle T+1. A load from any core issued after that `ack` returns the new value.
- Reset values: FSM = IDLE; `last` = `cores`-1, so core 0 wins first after reset. All outputs are 0.
- Reset asserted in ISSUE or RESP:
  - The FSM returns to IDLE on that edge.
  - No `ack` is emitted and `mem_we` drops immediately.
  - The aborted core still holds `req` and is re-arbitrated after reset.
- Reset has priority over every other transition.
- Index arithmetic for `last+1` wraps modulo `cores`. With `cores`=1 the winner is always 0.

## Structure
- Shared package `cpu_pkg`:
  - FSM state encoding: IDLE=2'd0, ISSUE=2'd1, RESP=2'd2.
  - Default data and address widths.
  - A `clog2`-style helper for the winner-index width.
- Sub-module `round_robin_picker`:
  - Combinational block; inputs are the `req` vector and `last` index.
  - Outputs are the one-hot grant and the binary winner index.
  - It is reused later for instruction-memory arbitration.
- Everything else (FSM, holding registers, output muxing) lives in `dm_arbiter`.

## Test plan
- Single load, `cores`=4: `dm[5]`=32'd6, core 2 reads address 5. `ack`=4'b0100 at T+2 with `rdata`=32'd6; no other `ack` bits pulse.
- Store then load: core 0 writes 32'd8 to address 0, then reads address 0. Read returns 32'd8; `mem_we` is high only in the store's ISSUE cycle.
- Simultaneous requests after reset: cores 1 and 3 request together. Core 1 is acked first at T+2, core 3 at T+5.
- Saturation: all 4 cores request continuously. `ack` order is 0,1,2,3,0,1 at 3-cycle spacing, with no core served twice before the others.
- Reset mid-transaction: reset asserted during ISSUE of a core 2 store. No `ack` appears, memory is unchanged if reset lands before the write edge, and core 2 is re-served first after reset with correct data.
- `cores`=1 string reversal: the 8-word swap program through the arbiter leaves memory[0..7] = 8,7,6,5,4,3,2,1 within the bench timeout.
